// File: rtl/apb_const_reader_pkg.sv
// Shared types and constants for the APB constant reader: FSM states,
// field widths of the fetched constant and the constant index encoding.
package apb_const_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP_H,
        ACCESS_H,
        SETUP_L,
        ACCESS_L,
        FIN
    } state_e;

    localparam int EXP_W     = 7;
    localparam int MANT_W    = 57;
    localparam int HI_MANT_W = 25;

    localparam logic [1:0] IDX_PI = 2'd0;
    localparam logic [1:0] IDX_E  = 2'd1;

    // Each constant occupies two consecutive words: high at 2*idx, low at 2*idx+1.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [1:0]  idx,
                                              input logic        low);
        return base + {29'd0, idx, low};
    endfunction

endpackage

// File: rtl/apb_rd_timer.sv
// Loadable down-counter bounding how long an APB access phase may wait for pready.
module apb_rd_timer #(
    parameter int P_WIDTH = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               dec_i,
    input  logic [P_WIDTH-1:0] load_val_i,
    output logic               last_o
);

    logic [P_WIDTH-1:0] count_q;
    logic [P_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - P_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted during the final permitted wait cycle of the access phase.
    assign last_o = (count_q <= P_WIDTH'(1));

endmodule

// File: rtl/apb_const_reader.sv
// APB master that fetches a 64-bit constant as two 32-bit reads and splits
// it into exponent and mantissa fields, with slave-error and timeout aborts.
module apb_const_reader
    import apb_const_reader_pkg::*;
#(
    parameter logic [31:0] P_DEVICE_OFFSET = 32'h7000_0000,
    parameter int          P_TIMEOUT       = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              start,
    input  logic [1:0]        const_idx,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [EXP_W-1:0]  exp_out,
    output logic [MANT_W-1:0] mant_out,
    output logic              psel,
    output logic              penable,
    output logic [31:0]       paddr,
    input  logic [31:0]       prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int TMR_W = $clog2(P_TIMEOUT + 1);

    state_e            state_q;
    state_e            state_d;
    logic [1:0]        idx_q;
    logic              err_q;
    logic [31:0]       hi_q;
    logic [EXP_W-1:0]  exp_q;
    logic [MANT_W-1:0] mant_q;

    logic accept;
    logic timer_load;
    logic timer_dec;
    logic timer_last;
    logic capture_hi;
    logic capture_lo;
    logic set_err;

    apb_rd_timer #(
        .P_WIDTH(TMR_W)
    ) u_timer (
        .clk_i      (pclk),
        .rst_i      (preset),
        .load_i     (timer_load),
        .dec_i      (timer_dec),
        .load_val_i (TMR_W'(P_TIMEOUT)),
        .last_o     (timer_last)
    );

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        capture_hi = 1'b0;
        capture_lo = 1'b0;
        set_err    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = SETUP_H;
                end
            end
            SETUP_H: begin
                timer_load = 1'b1;
                state_d    = ACCESS_H;
            end
            ACCESS_H: begin
                if (pready) begin
                    if (pslverr) begin
                        set_err = 1'b1;
                        state_d = FIN;
                    end else begin
                        capture_hi = 1'b1;
                        state_d    = SETUP_L;
                    end
                end else if (timer_last) begin
                    set_err = 1'b1;
                    state_d = FIN;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            SETUP_L: begin
                timer_load = 1'b1;
                state_d    = ACCESS_L;
            end
            ACCESS_L: begin
                if (pready) begin
                    if (pslverr) begin
                        set_err = 1'b1;
                    end else begin
                        capture_lo = 1'b1;
                    end
                    state_d = FIN;
                end else if (timer_last) begin
                    set_err = 1'b1;
                    state_d = FIN;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            err_q   <= 1'b0;
            hi_q    <= 32'd0;
            exp_q   <= '0;
            mant_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q <= const_idx;
                err_q <= 1'b0;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
            if (capture_hi) begin
                hi_q <= prdata;
            end
            // Result fields only change once both words have arrived cleanly.
            if (capture_lo) begin
                exp_q  <= hi_q[31:HI_MANT_W];
                mant_q <= {hi_q[HI_MANT_W-1:0], prdata};
            end
        end
    end

    always_comb begin
        psel    = 1'b0;
        penable = 1'b0;
        paddr   = 32'd0;
        case (state_q)
            SETUP_H: begin
                psel  = 1'b1;
                paddr = word_addr(P_DEVICE_OFFSET, idx_q, 1'b0);
            end
            ACCESS_H: begin
                psel    = 1'b1;
                penable = 1'b1;
                paddr   = word_addr(P_DEVICE_OFFSET, idx_q, 1'b0);
            end
            SETUP_L: begin
                psel  = 1'b1;
                paddr = word_addr(P_DEVICE_OFFSET, idx_q, 1'b1);
            end
            ACCESS_L: begin
                psel    = 1'b1;
                penable = 1'b1;
                paddr   = word_addr(P_DEVICE_OFFSET, idx_q, 1'b1);
            end
            default: begin
                psel    = 1'b0;
                penable = 1'b0;
                paddr   = 32'd0;
            end
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FIN);
    assign err      = err_q;
    assign exp_out  = exp_q;
    assign mant_out = mant_q;

endmodule

// File: tb/tb_apb_const_reader.sv
// Directed self-checking bench for apb_const_reader with a configurable
// APB slave model (wait states, slave error, hang).
module tb_apb_const_reader;

    logic        pclk = 1'b0;
    logic        preset;
    logic        start;
    logic [1:0]  const_idx;
    logic        busy;
    logic        done;
    logic        err;
    logic [6:0]  exp_out;
    logic [56:0] mant_out;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int compared   = 0;
    int mismatched = 0;

    int          waitStates = 0;
    bit          errHigh    = 1'b0;
    logic [31:0] hiWord     = 32'd0;
    logic [31:0] loWord     = 32'd0;
    int          accCnt     = 0;

    apb_const_reader dut (
        .pclk      (pclk),
        .preset    (preset),
        .start     (start),
        .const_idx (const_idx),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .exp_out   (exp_out),
        .mant_out  (mant_out),
        .psel      (psel),
        .penable   (penable),
        .paddr     (paddr),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    always #5 pclk = ~pclk;

    // Slave answers after waitStates extra access cycles; odd addresses are low words.
    always @(negedge pclk) begin
        if (psel && penable) begin
            pready = (accCnt >= waitStates);
            accCnt = accCnt + 1;
        end else begin
            pready = 1'b0;
            accCnt = 0;
        end
        prdata  = paddr[0] ? loWord : hiWord;
        pslverr = errHigh && !paddr[0] && pready;
    end

    // Runs one fetch from a negedge and leaves time at the negedge of the following IDLE cycle.
    task automatic doFetch(input logic [1:0] idx, input bit extraStarts,
                           output int latency, output logic [31:0] addrH,
                           output logic [31:0] addrL, output int nSetups,
                           output int nAccess, output bit pselDrop,
                           output bit tailActive);
        int cycles;
        bit seenSel;
        latency = 0; addrH = 32'd0; addrL = 32'd0; nSetups = 0; nAccess = 0;
        pselDrop = 1'b0; tailActive = 1'b1; seenSel = 1'b0;
        start = 1'b1;
        const_idx = idx;
        @(negedge pclk);
        start = 1'b0;
        cycles = 1;
        while (cycles < 200) begin
            if (psel && !penable) begin
                if (nSetups == 0) addrH = paddr;
                else addrL = paddr;
                nSetups++;
            end
            if (psel && penable) nAccess++;
            if (psel) seenSel = 1'b1;
            else if (seenSel && !done) pselDrop = 1'b1;
            if (done) begin
                latency = cycles;
                start = extraStarts;
                break;
            end
            start = extraStarts && (cycles == 2);
            @(negedge pclk);
            cycles++;
        end
        @(negedge pclk);
        start = 1'b0;
        tailActive = psel | penable | done | busy;
    endtask

    task automatic test_reset();
        preset = 1'b1; start = 1'b1; const_idx = 2'd1;
        repeat (3) @(negedge pclk);
        compared++;
        if ({psel, penable, busy, done, err} !== 5'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000", {psel, penable, busy, done, err});
        end
        compared++;
        if (paddr !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_paddr: got %h expected 00000000", paddr);
        end
        compared++;
        if (exp_out !== 7'd0 || mant_out !== 57'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_data: got %h/%h expected 0/0", exp_out, mant_out);
        end
        preset = 1'b0; start = 1'b0;
        @(negedge pclk);
    endtask

    task automatic test_zero_wait();
        int lat, ns, na; logic [31:0] ah, al; bit drop, tail;
        waitStates = 0; errHigh = 1'b0;
        hiWord = 32'hA5A5_0001; loWord = 32'h1234_5678;
        doFetch(2'd0, 1'b0, lat, ah, al, ns, na, drop, tail);
        compared++;
        if (lat !== 5) begin mismatched++; $display("[TB] FAIL zw_latency: got %0d expected 5", lat); end
        compared++;
        if (ah !== 32'h7000_0000 || al !== 32'h7000_0001) begin
            mismatched++; $display("[TB] FAIL zw_addr: got %h/%h expected 70000000/70000001", ah, al);
        end
        compared++;
        if (err !== 1'b0) begin mismatched++; $display("[TB] FAIL zw_err: got %b expected 0", err); end
        compared++;
        if (exp_out !== 7'h52) begin mismatched++; $display("[TB] FAIL zw_exp: got %h expected 52", exp_out); end
        compared++;
        if (mant_out !== 57'h1A50001_12345678) begin
            mismatched++; $display("[TB] FAIL zw_mant: got %h expected 1a5000112345678", mant_out);
        end
        compared++;
        if (tail !== 1'b0) begin mismatched++; $display("[TB] FAIL zw_tail: got %b expected 0", tail); end
    endtask

    task automatic test_slverr_high();
        int lat, ns, na; logic [31:0] ah, al; bit drop, tail;
        waitStates = 0; errHigh = 1'b1;
        hiWord = 32'hFFFF_FFFF; loWord = 32'h0000_0000;
        doFetch(2'd0, 1'b0, lat, ah, al, ns, na, drop, tail);
        errHigh = 1'b0;
        compared++;
        if (lat !== 3) begin mismatched++; $display("[TB] FAIL se_latency: got %0d expected 3", lat); end
        compared++;
        if (ns !== 1) begin mismatched++; $display("[TB] FAIL se_setups: got %0d expected 1", ns); end
        compared++;
        if (err !== 1'b1) begin mismatched++; $display("[TB] FAIL se_err: got %b expected 1", err); end
        compared++;
        if (exp_out !== 7'h52 || mant_out !== 57'h1A50001_12345678) begin
            mismatched++; $display("[TB] FAIL se_hold: got %h/%h expected 52/1a5000112345678", exp_out, mant_out);
        end
    endtask

    task automatic test_timeout();
        int lat, ns, na; logic [31:0] ah, al; bit drop, tail;
        waitStates = 1000; errHigh = 1'b0;
        doFetch(2'd1, 1'b0, lat, ah, al, ns, na, drop, tail);
        waitStates = 0;
        compared++;
        if (lat !== 18) begin mismatched++; $display("[TB] FAIL to_latency: got %0d expected 18", lat); end
        compared++;
        if (na !== 16) begin mismatched++; $display("[TB] FAIL to_access: got %0d expected 16", na); end
        compared++;
        if (ns !== 1) begin mismatched++; $display("[TB] FAIL to_setups: got %0d expected 1", ns); end
        compared++;
        if (err !== 1'b1) begin mismatched++; $display("[TB] FAIL to_err: got %b expected 1", err); end
        compared++;
        if (tail !== 1'b0) begin mismatched++; $display("[TB] FAIL to_psel_after: got %b expected 0", tail); end
        compared++;
        if (exp_out !== 7'h52) begin mismatched++; $display("[TB] FAIL to_hold: got %h expected 52", exp_out); end
    endtask

    task automatic test_wait_states();
        int lat, ns, na; logic [31:0] ah, al; bit drop, tail;
        waitStates = 3; errHigh = 1'b0;
        hiWord = 32'h8000_0003; loWord = 32'hDEAD_BEEF;
        doFetch(2'd1, 1'b0, lat, ah, al, ns, na, drop, tail);
        waitStates = 0;
        compared++;
        if (lat !== 11) begin mismatched++; $display("[TB] FAIL ws_latency: got %0d expected 11", lat); end
        compared++;
        if (ah !== 32'h7000_0002 || al !== 32'h7000_0003) begin
            mismatched++; $display("[TB] FAIL ws_addr: got %h/%h expected 70000002/70000003", ah, al);
        end
        compared++;
        if (drop !== 1'b0) begin mismatched++; $display("[TB] FAIL ws_psel_gap: got %b expected 0", drop); end
        compared++;
        if (na !== 8) begin mismatched++; $display("[TB] FAIL ws_access: got %0d expected 8", na); end
        compared++;
        if (err !== 1'b0) begin mismatched++; $display("[TB] FAIL ws_err: got %b expected 0", err); end
        compared++;
        if (exp_out !== 7'h40 || mant_out !== 57'h0000003_DEADBEEF) begin
            mismatched++; $display("[TB] FAIL ws_data: got %h/%h expected 40/3deadbeef", exp_out, mant_out);
        end
    endtask

    task automatic test_reset_mid();
        int lat, ns, na, spurious; logic [31:0] ah, al; bit drop, tail, found;
        waitStates = 3; errHigh = 1'b0;
        hiWord = 32'hA5A5_0001; loWord = 32'h1234_5678;
        start = 1'b1; const_idx = 2'd0;
        @(negedge pclk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (psel && penable && paddr[0]) begin found = 1'b1; break; end
            @(negedge pclk);
        end
        compared++;
        if (found !== 1'b1) begin mismatched++; $display("[TB] FAIL rm_reach_access_l: got %b expected 1", found); end
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        compared++;
        if ({psel, penable, done, busy, err} !== 5'b0) begin
            mismatched++; $display("[TB] FAIL rm_ctrl: got %b expected 00000", {psel, penable, done, busy, err});
        end
        compared++;
        if (exp_out !== 7'd0 || mant_out !== 57'd0) begin
            mismatched++; $display("[TB] FAIL rm_zeroed: got %h/%h expected 0/0", exp_out, mant_out);
        end
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            if (done || busy) spurious++;
        end
        compared++;
        if (spurious !== 0) begin mismatched++; $display("[TB] FAIL rm_no_done: got %0d expected 0", spurious); end
        waitStates = 0;
        doFetch(2'd0, 1'b0, lat, ah, al, ns, na, drop, tail);
        compared++;
        if (lat !== 5 || mant_out !== 57'h1A50001_12345678) begin
            mismatched++; $display("[TB] FAIL rm_recover: got %0d/%h expected 5/1a5000112345678", lat, mant_out);
        end
    endtask

    task automatic test_back_to_back();
        int lat, ns, na, extraBusy; logic [31:0] ah, al; bit drop, tail;
        waitStates = 0; errHigh = 1'b0;
        hiWord = 32'h0246_8ACE; loWord = 32'h1357_9BDF;
        doFetch(2'd0, 1'b1, lat, ah, al, ns, na, drop, tail);
        compared++;
        if (ns !== 2 || lat !== 5) begin
            mismatched++; $display("[TB] FAIL bb_single_fetch: got %0d setups/%0d cycles expected 2/5", ns, lat);
        end
        compared++;
        if (tail !== 1'b0) begin mismatched++; $display("[TB] FAIL bb_fin_start: got %b expected 0", tail); end
        extraBusy = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            if (busy) extraBusy++;
        end
        compared++;
        if (extraBusy !== 0) begin mismatched++; $display("[TB] FAIL bb_idle: got %0d expected 0", extraBusy); end
        compared++;
        if (exp_out !== 7'h01 || mant_out !== 57'h0468ACE_13579BDF) begin
            mismatched++; $display("[TB] FAIL bb_data: got %h/%h expected 01/468ace13579bdf", exp_out, mant_out);
        end
        doFetch(2'd1, 1'b0, lat, ah, al, ns, na, drop, tail);
        doFetch(2'd0, 1'b0, lat, ah, al, ns, na, drop, tail);
        compared++;
        if (lat !== 5 || ah !== 32'h7000_0000) begin
            mismatched++; $display("[TB] FAIL bb_first_idle_start: got %0d/%h expected 5/70000000", lat, ah);
        end
    endtask

    initial begin
        preset = 1'b1; start = 1'b0; const_idx = 2'd0;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'd0;
        @(negedge pclk);
        test_reset();
        test_zero_wait();
        test_slverr_high();
        test_timeout();
        test_wait_states();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/apb_const_reader.md
APB_CONST_READER -- requirements
Module: apb_const_reader

Interface
REQ-001 SHALL have parameter P_DEVICE_OFFSET, default 32'h7000_0000: APB base address of the constant slave.
REQ-002 SHALL have parameter P_TIMEOUT, default 16: maximum access-phase cycles waited for pready.
REQ-003 SHALL have port pclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port preset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: request a constant fetch.
REQ-006 SHALL have port const_idx, input, 2 bits: constant select (0=pi, 1=e, 2/3 reserved); sampled on an accepted start.
REQ-007 SHALL have port busy, output, 1 bit: fetch in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse at fetch end, success or error.
REQ-009 SHALL have port err, output, 1 bit: last fetch failed (pslverr or timeout); valid from done onward.
REQ-010 SHALL have port exp_out, output, 7 bits: exponent field of the fetched constant.
REQ-011 SHALL have port mant_out, output, 57 bits: mantissa of the fetched constant.
REQ-012 SHALL have APB master ports psel (output, 1), penable (output, 1) and paddr (output, 32).
REQ-013 SHALL have APB master inputs prdata (32), pready (1) and pslverr (1).

Function
REQ-014 SHALL implement FSM states IDLE, SETUP_H, ACCESS_H, SETUP_L, ACCESS_L and FIN.
REQ-015 IDLE: start=1 -> SETUP_H, latch const_idx, clear err; start while busy SHALL be ignored.
REQ-016 SETUP_x: psel=1, penable=0, paddr valid, for exactly one cycle, then -> ACCESS_x.
REQ-017 Address rule: high word at P_DEVICE_OFFSET+2*idx, low word at P_DEVICE_OFFSET+2*idx+1, 32-bit wrap-around.
REQ-018 ACCESS_x: psel=1, penable=1, paddr held stable until the cycle in which pready=1.
REQ-019 On pready=1 with pslverr=0, prdata SHALL be captured that same edge; ACCESS_H -> SETUP_L and ACCESS_L -> FIN.
REQ-020 psel SHALL stay 1 across the SETUP_L transition (back-to-back transfer); penable SHALL drop to 0 for SETUP_L.
REQ-021 pready=1 with pslverr=1 in either access SHALL abort: err=1 -> FIN; the low read is skipped if the high read fails.
REQ-022 Timeout: an access-phase cycle counter reloads on each SETUP entry; P_TIMEOUT cycles without pready SHALL abort with err=1 -> FIN.
REQ-023 FIN: psel=0, penable=0, done=1 for one cycle -> IDLE; busy=1 in every state except IDLE.
REQ-024 On success, exp_out SHALL be high[31:25] and mant_out SHALL be {high[24:0], low}, updated on the FIN entry edge.
REQ-025 On error, exp_out and mant_out SHALL hold their previous values.
REQ-026 Outputs SHALL hold until the next successful fetch; total latency with zero-wait slave = 5 cycles from start to done.
REQ-027 start asserted in the FIN cycle SHALL be ignored; start asserted in the first IDLE cycle after FIN SHALL be accepted.

Reset
REQ-028 preset=1 SHALL force IDLE: psel=0, penable=0, paddr=0, busy=0, done=0, err=0, exp_out=0, mant_out=0, counter=0.
REQ-029 Reset mid-transfer SHALL drop psel/penable at the next edge with no done pulse.
REQ-030 Reset SHALL take priority over start.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the field-width constants (EXP_W=7, MANT_W=57, HI_MANT_W=25) and the constant index values (IDX_PI, IDX_E).
REQ-032 One sub-module, apb_rd_timer, SHALL implement the loadable timeout down-counter; all other logic stays in one module.

Verification
REQ-033 Zero-wait slave returning 32'hA5A5_0001 then 32'h1234_5678, idx=0 -> paddr 7000_0000 then 7000_0001, exp_out=7'h52, mant_out=57'h1A50001_12345678, done 5 cycles after start, err=0.
REQ-034 idx=1 with 3 wait states per access -> paddr 7000_0002/7000_0003, done 11 cycles after start, psel continuous from SETUP_H to ACCESS_L.
REQ-035 pslverr=1 on the high read -> no low read issued, err=1, done pulse, exp_out/mant_out unchanged from REQ-033.
REQ-036 pready held 0 -> abort after 16 access cycles, err=1, psel=0 the cycle after done.
REQ-037 preset pulse during ACCESS_L -> psel=0 next edge, no done, outputs zeroed; next start completes normally.
REQ-038 start re-pulsed while busy and during FIN -> ignored, exactly one fetch is performed.
